// File: rtl/swreg_pkg.sv
// rtl/swreg_pkg.sv - register map constants and data width shared by swreg and its bus masters
package swreg_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ADDR_STATE = 2'b00,
        ADDR_EVENT = 2'b01,
        ADDR_MASK  = 2'b10,
        ADDR_RSVD  = 2'b11
    } reg_addr_e;

endpackage

// File: rtl/swreg_if.sv
// rtl/swreg_if.sv - simple peripheral bus (wr_en/rd_en strobes, registered read data)
interface swreg_if import swreg_pkg::*; #(
    parameter int WIDTH = DATA_WIDTH
);
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       addr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;

    modport master (
        output wr_en, rd_en, addr, data_in,
        input  data_out
    );

    modport slave (
        input  wr_en, rd_en, addr, data_in,
        output data_out
    );
endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser and counting debouncer for one input pin
module debounce_bit #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic          w_done;

    // The edge on which the count would reach DB_CYCLES is the flip edge, so
    // the counter itself never holds DB_CYCLES and cannot wrap.
    assign w_done = (r_sync2 != r_db) && (r_cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_db;
    assign o_rise  = w_done && r_sync2;
endmodule

// File: rtl/swreg.sv
// rtl/swreg.sv - debounced switch input register with sticky rising-edge events and maskable irq
module swreg import swreg_pkg::*; #(
    parameter int WIDTH     = DATA_WIDTH,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             nreset,
    swreg_if.slave           bus,
    input  logic [WIDTH-1:0] sw_port,
    output logic             irq
);
    logic [WIDTH-1:0] w_state;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_ev_clr;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] r_event;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_dout;
    logic             r_irq;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .nreset (nreset),
            .i_pin  (sw_port[i]),
            .o_level(w_state[i]),
            .o_rise (w_rise[i])
        );
    end

    assign w_ev_clr = (bus.wr_en && (bus.addr == ADDR_EVENT)) ? bus.data_in : '0;

    always_comb begin
        w_rdata = '0;
        case (reg_addr_e'(bus.addr))
            ADDR_STATE: w_rdata = w_state;
            ADDR_EVENT: w_rdata = r_event;
            ADDR_MASK:  w_rdata = r_mask;
            default:    w_rdata = '0;
        endcase
    end

    // Read mux samples pre-write register values, so a same-cycle read and
    // write returns the old contents; a new rise beats a W1C clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_event <= '0;
            r_mask  <= '0;
            r_dout  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_event <= (r_event & ~w_ev_clr) | w_rise;
            if (bus.wr_en && (bus.addr == ADDR_MASK)) begin
                r_mask <= bus.data_in;
            end
            r_irq <= |(r_event & r_mask);
            if (bus.rd_en) begin
                r_dout <= w_rdata;
            end
        end
    end

    assign bus.data_out = r_dout;
    assign irq          = r_irq;
endmodule
